// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction fetch memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Word-index width for a memory of the given depth.
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Load-stream and fetch bus of the instruction memory; master drives, slave is the memory.
interface instr_fetch_mem_if
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = idx_w(DEPTH) + 1;

  logic              load_start_i;
  logic              load_valid_i;
  logic [DATA_W-1:0] load_data_i;
  logic              load_last_i;
  logic              load_busy_o;
  logic [CNT_W-1:0]  load_count_o;
  logic              fetch_req_i;
  logic [ADDR_W-1:0] pc_addr_i;
  logic              stall_i;
  logic [DATA_W-1:0] instr_o;
  logic              instr_valid_o;
  logic              fetch_err_o;

  modport master (
    output load_start_i, load_valid_i, load_data_i, load_last_i,
    output fetch_req_i, pc_addr_i, stall_i,
    input  load_busy_o, load_count_o, instr_o, instr_valid_o, fetch_err_o
  );

  modport slave (
    input  load_start_i, load_valid_i, load_data_i, load_last_i,
    input  fetch_req_i, pc_addr_i, stall_i,
    output load_busy_o, load_count_o, instr_o, instr_valid_o, fetch_err_o
  );

endinterface

// File: rtl/instr_mem_array.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on data.
module instr_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Read register only advances on an enabled read so it doubles as the stall hold.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_fetch_mem.sv
// Run-time loadable instruction memory: load FSM, bounds/alignment check and stall-held fetch output.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 32,
  parameter int              ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  instr_fetch_mem_if.slave bus
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  state_t            r_state, w_state_next;
  logic [IDX_W-1:0]  r_wptr, w_wptr_next, w_wr_addr;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic              w_wr_en, w_wr_done;

  logic [ADDR_W-3:0] w_word_idx;
  logic              w_accept, w_err, w_rd_en;
  logic              r_valid, r_err, r_hit;
  logic [DATA_W-1:0] w_rd_data;

  always_comb begin
    w_state_next = r_state;
    w_wptr_next  = r_wptr;
    w_count_next = r_count;
    // A restart in LOAD redirects any same-cycle write to word 0.
    w_wr_addr    = bus.load_start_i ? '0 : r_wptr;
    w_wr_en      = (r_state == ST_LOAD) && bus.load_valid_i;
    w_wr_done    = w_wr_en && (bus.load_last_i || (w_wr_addr == IDX_W'(DEPTH - 1)));

    if (bus.load_start_i) begin
      w_wptr_next  = '0;
      w_count_next = '0;
    end
    if (w_wr_en) begin
      w_wptr_next  = w_wr_addr + 1'b1;
      w_count_next = (bus.load_start_i ? CNT_W'(0) : r_count) + CNT_W'(1);
    end

    case (r_state)
      ST_IDLE: if (bus.load_start_i) w_state_next = ST_LOAD;
      ST_LOAD: if (w_wr_done)        w_state_next = ST_RUN;
      ST_RUN:  if (bus.load_start_i) w_state_next = ST_LOAD;
      default:                       w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_wptr  <= w_wptr_next;
      r_count <= w_count_next;
    end
  end

  // Full-width index compare so out-of-range PCs never alias into the array.
  assign w_word_idx = bus.pc_addr_i[ADDR_W-1:2];
  assign w_err      = (|bus.pc_addr_i[1:0]) || (w_word_idx >= (ADDR_W-2)'(DEPTH));
  assign w_accept   = (r_state == ST_RUN) && bus.fetch_req_i && !bus.stall_i && !bus.load_start_i;
  assign w_rd_en    = w_accept && !w_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_hit   <= 1'b0;
    end else if (!bus.stall_i) begin
      r_valid <= w_accept;
      r_err   <= w_accept && w_err;
      r_hit   <= w_rd_en;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk     (clk_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.load_data_i),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_word_idx[IDX_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign bus.instr_o       = r_hit ? w_rd_data : NOP_WORD;
  assign bus.instr_valid_o = r_valid;
  assign bus.fetch_err_o   = r_err;
  assign bus.load_busy_o   = (r_state == ST_LOAD);
  assign bus.load_count_o  = r_count;

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, loadable instruction memory for the single-cycle/pipelined CPU fetch stage. Replaces the fixed 32-word initialised ROM with a synchronous-read array that is filled at run time through a streaming load port, guarded by a small load FSM. Fetch reads take one cycle, obey a stall hold, and flag misaligned or out-of-range PCs instead of aliasing them.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 32, number of instruction words (power of two, ≥2)
- ADDR_W, 32, byte-address width of pc_addr_i
- NOP_WORD, 32'h0000_0000, value driven on error, after reset and when no instruction is valid
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- load_start_i  in  1  begin (re)load; write pointer returns to word 0
- load_valid_i  in  1  load_data_i is valid this cycle
- load_data_i  in  DATA_W  instruction word to store
- load_last_i  in  1  qualifies the final word of a load burst
- load_busy_o  out  1  FSM in LOAD
- load_count_o  out  $clog2(DEPTH)+1  words written by the current/last load
- fetch_req_i  in  1  fetch request for pc_addr_i
- pc_addr_i  in  ADDR_W  byte address of the instruction
- stall_i  in  1  downstream stall; hold outputs, accept no request
- instr_o  out  DATA_W  fetched instruction (registered)
- instr_valid_o  out  1  instr_o holds a served fetch
- fetch_err_o  out  1  served fetch was misaligned or out of range

## Operation
- FSM states: IDLE (reset state, memory content undefined), LOAD, RUN.
- IDLE → LOAD on load_start_i. RUN → LOAD on load_start_i. LOAD → RUN after the write carrying load_last_i, or after the write to word DEPTH-1, whichever is first.
- load_start_i while already in LOAD: restart, pointer and load_count_o cleared; a load_valid_i in that same cycle writes word 0.
- LOAD write: when load_valid_i, mem[wptr] ← load_data_i, wptr++, load_count_o++. No write when load_valid_i low. Writes are impossible outside LOAD.
- Fetch served only in RUN with fetch_req_i=1, stall_i=0, and load_start_i=0.
- Index = pc_addr_i >> 2. Error if pc_addr_i[1:0] ≠ 0 or index ≥ DEPTH (upper bits not truncated). Error → instr_o=NOP_WORD, fetch_err_o=1, instr_valid_o=1.
- Fetch in RUN with no request: instr_valid_o=0, fetch_err_o=0, instr_o=NOP_WORD.
- Fetch request in IDLE or LOAD: dropped, instr_valid_o=0, instr_o=NOP_WORD.
- Words at index ≥ load_count_o but < DEPTH return stale array contents without error.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, instr_o=NOP_WORD, instr_valid_o=0, fetch_err_o=0, load_busy_o=0, load_count_o=0, wptr=0. Array contents not cleared.
- Fetch latency 1 cycle: request at edge N → instr_o/instr_valid_o/fetch_err_o valid after edge N+1.
- stall_i=1: instr_o, instr_valid_o, fetch_err_o hold their values; request not accepted.
- load_busy_o asserts the cycle after load_start_i is sampled; deasserts the cycle after the final write.
- First fetch may be accepted in the cycle after LOAD → RUN; reads see the newest write (no read-during-write hazard reachable).
- load_start_i and fetch_req_i in the same RUN cycle: load wins, fetch dropped, instr_valid_o=0 next cycle.
- Reset mid-load: FSM to IDLE, count 0; partially written words remain but are unreachable until a new load completes.

## Structure
- Package instr_mem_pkg: state enum {IDLE, LOAD, RUN}, default NOP_WORD, index-width helper ($clog2(DEPTH)).
- Sub-module instr_mem_array: 1-write/1-read synchronous RAM (DATA_W × DEPTH, registered read, no reset) so it can map to block RAM; FSM, error check, and output/stall hold live in the top.

## Test plan
- Reset then fetch pc=0 → instr_valid_o=0, instr_o=0x00000000, load_busy_o=0.
- Load 22 words (last on word 21, word1=0x2009000A) → load_count_o=22, RUN; fetch pc=4 → next cycle instr_o=0x2009000A, valid=1, err=0.
- Fetch pc=0x82 and pc=0x80 with DEPTH=32 → both err=1, instr_o=0, valid=1.
- Stream 32 words without load_last_i → auto RUN after word 31, load_count_o=32; a 33rd load_valid_i is ignored.
- Fetch pc=8 then stall_i=1 for 3 cycles while pc changes → instr_o holds word2; release → new pc served one cycle later.
- Assert rst_i low after 5 load writes, then reload 3 words → load_count_o=3, fetch pc=8 returns new word2.
